// File: rtl/ram16x1_arbiter_pkg.sv
// Shared constants and types for the 16x1 RAM arbiter.
package ram16x1_arbiter_pkg;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    // Controller states: post-reset clearing sweep, then normal arbitration.
    typedef enum logic [0:0] {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

    // Outstanding read: completes on the edge after its grant.
    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/ram16x1_arbiter_rr_arb2.sv
// Two-way round-robin picker: purely combinational.
module ram16x1_arbiter_rr_arb2 (
    input  logic [1:0] elig_i,
    input  logic       ptr_i,
    output logic [1:0] win_o,
    output logic       ptr_o
);

    // Single eligible request wins outright; a tie goes to the pointer.
    always_comb begin
        win_o = 2'b00;
        ptr_o = ptr_i;
        unique case (elig_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = ptr_i ? 2'b10 : 2'b01;
            default: win_o = 2'b00;
        endcase
        // After a grant the pointer favours the requester that lost.
        if (win_o != 2'b00) begin
            ptr_o = win_o[0];
        end
    end

endmodule

// File: rtl/ram16x1_arbiter.sv
// Two-requester controller for a 16x1 write-clocked RAM: clears the RAM after
// reset, then shares its port with registered round-robin grants and returns
// read data one cycle after the grant.
module ram16x1_arbiter
    import ram16x1_arbiter_pkg::*;
#(
    parameter logic INIT_VAL = 1'b0,
    parameter bit   DO_INIT  = 1'b1
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              wr0_i,
    input  logic              wr1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic              wdata0_i,
    input  logic              wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic              rdata_o,
    output logic              busy_o,
    output logic              ram_d_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_we_o,
    input  logic              ram_q_i
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              rdata_q, rdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              d_q, d_d;
    rd_tag_t           tag_q, tag_d;

    logic [1:0]        elig;
    logic [1:0]        win;
    logic              arb_ptr;

    // A request whose grant is still showing is not re-granted.
    assign elig = {req1_i & ~gnt_q[1], req0_i & ~gnt_q[0]};

    ram16x1_arbiter_rr_arb2 u_rr_arb2 (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .win_o  (win),
        .ptr_o  (arb_ptr)
    );

    // Next-state: init sweep, grant registration and read completion.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        we_d     = 1'b0;
        a_d      = a_q;
        d_d      = d_q;
        tag_d    = '0;

        // Read granted last edge: RAM output is valid on a_q now.
        if (tag_q.vld) begin
            rdata_d            = ram_q_i;
            rvalid_d[tag_q.id] = 1'b1;
        end

        unique case (state_q)
            StInit: begin
                if (!DO_INIT) begin
                    state_d = StRun;
                end else if (we_q && (a_q == LastAddr)) begin
                    // Last location is being written on this edge.
                    state_d = StRun;
                end else begin
                    we_d  = 1'b1;
                    a_d   = cnt_q;
                    d_d   = INIT_VAL;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                ptr_d = arb_ptr;
                gnt_d = win;
                if (win[0]) begin
                    a_d   = addr0_i;
                    d_d   = wdata0_i;
                    we_d  = wr0_i;
                    tag_d = '{vld: ~wr0_i, id: 1'b0};
                end else if (win[1]) begin
                    a_d   = addr1_i;
                    d_d   = wdata1_i;
                    we_d  = wr1_i;
                    tag_d = '{vld: ~wr1_i, id: 1'b1};
                end
            end
            default: state_d = StInit;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wclk) begin
        if (rst) begin
            state_q  <= StInit;
            ptr_q    <= 1'b0;
            cnt_q    <= '0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            rdata_q  <= 1'b0;
            we_q     <= 1'b0;
            a_q      <= '0;
            d_q      <= 1'b0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            a_q      <= a_d;
            d_q      <= d_d;
            tag_q    <= tag_d;
        end
    end

    assign gnt0_o    = gnt_q[0];
    assign gnt1_o    = gnt_q[1];
    assign rvalid0_o = rvalid_q[0];
    assign rvalid1_o = rvalid_q[1];
    assign rdata_o   = rdata_q;
    assign busy_o    = (state_q == StInit);
    assign ram_d_o   = d_q;
    assign ram_a_o   = a_q;
    assign ram_we_o  = we_q;

endmodule

// File: tb/tb_ram16x1_arbiter.sv
// Self-checking bench: backdoor RAM models, scoreboard of expected read data.
module tb_ram16x1_arbiter;

    logic       wclk;
    logic       rst;
    logic       req0, req1, wr0, wr1, wdata0, wdata1;
    logic [3:0] addr0, addr1;

    logic       gnt0, gnt1, rvalid0, rvalid1, rdata, busy, ram_d, ram_we, ram_q;
    logic [3:0] ram_a;
    logic       gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, rdata_b, busy_b;
    logic       ram_d_b, ram_we_b, ram_q_b;
    logic [3:0] ram_a_b;

    // Backdoor controls into the RAM models.
    logic       bd_all, bd_one, bd_val;
    logic [3:0] bd_addr;

    logic       mem_a [16];
    logic       mem_b [16];
    logic       model [16];
    logic       exp0_q [$];
    logic       exp1_q [$];

    int         n_chk = 0;
    int         n_bad = 0;

    ram16x1_arbiter u_dut (
        .wclk      (wclk),
        .rst       (rst),
        .req0_i    (req0),
        .req1_i    (req1),
        .wr0_i     (wr0),
        .wr1_i     (wr1),
        .addr0_i   (addr0),
        .addr1_i   (addr1),
        .wdata0_i  (wdata0),
        .wdata1_i  (wdata1),
        .gnt0_o    (gnt0),
        .gnt1_o    (gnt1),
        .rvalid0_o (rvalid0),
        .rvalid1_o (rvalid1),
        .rdata_o   (rdata),
        .busy_o    (busy),
        .ram_d_o   (ram_d),
        .ram_a_o   (ram_a),
        .ram_we_o  (ram_we),
        .ram_q_i   (ram_q)
    );

    // Second instance only exercises the sweep with INIT_VAL=1.
    ram16x1_arbiter #(.INIT_VAL(1'b1), .DO_INIT(1'b1)) u_dut_b (
        .wclk      (wclk),
        .rst       (rst),
        .req0_i    (1'b0),
        .req1_i    (1'b0),
        .wr0_i     (1'b0),
        .wr1_i     (1'b0),
        .addr0_i   (4'd0),
        .addr1_i   (4'd0),
        .wdata0_i  (1'b0),
        .wdata1_i  (1'b0),
        .gnt0_o    (gnt0_b),
        .gnt1_o    (gnt1_b),
        .rvalid0_o (rvalid0_b),
        .rvalid1_o (rvalid1_b),
        .rdata_o   (rdata_b),
        .busy_o    (busy_b),
        .ram_d_o   (ram_d_b),
        .ram_a_o   (ram_a_b),
        .ram_we_o  (ram_we_b),
        .ram_q_i   (ram_q_b)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // 16x1 RAMs: clocked write, combinational read, plus backdoor fill.
    always @(posedge wclk) begin
        if (bd_all) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= bd_val;
                mem_b[i] <= ~bd_val;
            end
        end else begin
            if (bd_one) mem_a[bd_addr] <= bd_val;
            if (ram_we) mem_a[ram_a] <= ram_d;
            if (ram_we_b) mem_b[ram_a_b] <= ram_d_b;
        end
    end
    assign ram_q   = mem_a[ram_a];
    assign ram_q_b = mem_b[ram_a_b];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    // Issue one access and wait (bounded) for its grant; reads also check rvalid timing.
    task automatic do_req(input int id, input logic wr, input logic [3:0] a, input logic d);
        logic got;
        got = 1'b0;
        if (id == 0) begin
            req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = d;
            if (!wr) exp0_q.push_back(model[a]);
        end else begin
            req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = d;
            if (!wr) exp1_q.push_back(model[a]);
        end
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            got = (id == 0) ? gnt0 : gnt1;
        end
        check("gnt_seen", {31'd0, got}, 1);
        if (id == 0) req0 = 1'b0;
        else         req1 = 1'b0;
        if (wr) begin
            model[a] = d;
        end else begin
            tick();
            check("rvalid_lat", {31'd0, (id == 0) ? rvalid0 : rvalid1}, 1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, {24'd0, gnt0, gnt1, rvalid0, rvalid1, rdata, ram_we, ram_d, busy}, 32'h01);
        check({tag, "_a"}, {28'd0, ram_a}, 0);
    endtask

    logic [15:0] va, vb;
    logic        r_wr, r_d;
    logic [3:0]  r_a;
    int          r_id;
    logic        got_g;

    initial begin
        rst = 1'b1;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd3; wdata0 = 1'b0;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'd9; wdata1 = 1'b0;
        bd_all = 1'b1; bd_val = 1'b1; bd_one = 1'b0; bd_addr = 4'd0;

        // Read-data monitor: every rvalid must match the scoreboard head.
        fork
            forever begin
                @(negedge wclk);
                if (rvalid0) begin
                    if (exp0_q.size() == 0) check("rv0_unexpected", {31'd0, rvalid0}, 0);
                    else check("rdata0", {31'd0, rdata}, {31'd0, exp0_q.pop_front()});
                end
                if (rvalid1) begin
                    if (exp1_q.size() == 0) check("rv1_unexpected", {31'd0, rvalid1}, 0);
                    else check("rdata1", {31'd0, rdata}, {31'd0, exp1_q.pop_front()});
                end
            end
        join_none

        tick();
        bd_all = 1'b0;
        check_reset_vals("reset");
        tick();
        rst = 1'b0;

        // Sweep, requests ignored during INIT, then held contention.
        for (int k = 0; k <= 20; k++) begin
            tick();
            if (k <= 15) begin
                check($sformatf("sweep_we_e%0d", k), {31'd0, ram_we}, 1);
                check($sformatf("sweep_a_e%0d", k), {28'd0, ram_a}, k);
                check($sformatf("sweep_busy_e%0d", k), {30'd0, busy, busy_b}, 3);
                check($sformatf("init_nognt_e%0d", k), {30'd0, gnt0, gnt1}, 0);
            end else if (k == 16) begin
                check("sweep_end", {28'd0, busy, ram_we, gnt0, gnt1}, 0);
                check("sweep_end_b", {30'd0, busy_b, ram_we_b}, 0);
                for (int i = 0; i < 16; i++) begin
                    va[i] = mem_a[i];
                    vb[i] = mem_b[i];
                    model[i] = 1'b0;
                end
                check("sweep_mem0", {16'd0, va}, 32'h0000);
                check("sweep_mem1", {16'd0, vb}, 32'hffff);
                check("b_quiet", {27'd0, gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, rdata_b}, 0);
                bd_one = 1'b1; bd_addr = 4'd3; bd_val = 1'b1;
                model[3] = 1'b1;
                exp0_q.push_back(1'b1); exp0_q.push_back(1'b1);
                exp1_q.push_back(1'b0); exp1_q.push_back(1'b0);
            end else begin
                bd_one = 1'b0;
                check($sformatf("rr_gnt_e%0d", k), {30'd0, gnt1, gnt0},
                      (k % 2 == 1) ? 32'd1 : 32'd2);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();

        // Single write then read.
        do_req(0, 1'b1, 4'd5, 1'b1);
        do_req(0, 1'b0, 4'd5, 1'b0);

        // Back-to-back write by 1, read by 0 of the same address.
        do_req(1, 1'b1, 4'd7, 1'b1);
        do_req(0, 1'b0, 4'd7, 1'b0);
        do_req(1, 1'b1, 4'd7, 1'b0);
        do_req(0, 1'b0, 4'd7, 1'b0);

        // Mixed random accesses.
        for (int i = 0; i < 8; i++) begin
            r_id = int'($urandom_range(1));
            r_wr = 1'($urandom_range(1));
            r_a  = 4'($urandom_range(15));
            r_d  = 1'($urandom_range(1));
            do_req(r_id, r_wr, r_a, r_d);
        end

        // Reset one cycle after a read grant: the read must not complete.
        do_req(1, 1'b1, 4'd2, 1'b1);
        do_req(0, 1'b0, 4'd2, 1'b0);
        req0 = 1'b1; wr0 = 1'b0; addr0 = 4'd2;
        got_g = 1'b0;
        for (int i = 0; i < 20 && !got_g; i++) begin
            tick();
            got_g = gnt0;
        end
        check("midread_gnt", {31'd0, got_g}, 1);
        rst = 1'b1; req0 = 1'b0;
        tick();
        check_reset_vals("midread_rst");
        tick();

        // Reset at E8 of a sweep: the sweep restarts from address 0.
        rst = 1'b0;
        tick();
        check("resweep_e0", {27'd0, ram_we, ram_a}, 32'h10);
        for (int i = 1; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        check_reset_vals("midsweep_rst");
        rst = 1'b0;
        tick();
        check("restart_e0", {26'd0, busy, ram_we, ram_a}, 32'h30);
        tick();
        check("restart_e1", {26'd0, busy, ram_we, ram_a}, 32'h31);
        for (int i = 0; i < 40 && busy; i++) tick();
        check("restart_done", {31'd0, busy}, 0);
        for (int i = 0; i < 16; i++) model[i] = 1'b0;
        do_req(1, 1'b0, 4'd2, 1'b0);
        do_req(0, 1'b0, 4'd5, 1'b0);

        repeat (3) tick();
        check("sb0_drained", exp0_q.size(), 0);
        check("sb1_drained", exp1_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
